// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: request opcodes,
// controller FSM states and default interface widths.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_NUM_WORDS = 16;
  localparam int DEF_RD_LAT    = 1;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  // ST_VERIFY is only reachable when write verification is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_VERIFY,
    ST_CLEAR,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_rd_timer.sv
// Read-latency timer: loaded with RD_LAT when a read phase starts, counts down
// while enabled and strobes done on the last cycle of the read phase, i.e. the
// cycle whose closing edge samples valid memory read data.
module mem_rd_timer #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int CW = $clog2(RD_LAT + 1);

  logic [CW-1:0] cnt_q;

  // Down-counter holding the remaining read-phase cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(RD_LAT);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done = en && (cnt_q == CW'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the data-memory bank. Accepts one LOAD, STORE
// or CLEAR request at a time over a valid/ready channel, sequences the bank's
// r_w / address / data pins and returns one response per request.
// Optional feature: define MEM_CTRL_WRITE_VERIFY_EN to read back every STORE
// and flag a mismatch on rsp_err.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [ADDR_W-1:0] mem_addr_in,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              r_w,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic                tmr_load;
  logic                tmr_en;
  logic                tmr_done;
  logic                accept;
  logic                rsp_fire;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign tmr_en    = (state_q == ST_READ) || (state_q == ST_VERIFY);

  mem_rd_timer #(
    .RD_LAT (RD_LAT)
  ) u_rd_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .en    (tmr_en),
    .done  (tmr_done)
  );

  // State register; an asynchronous reset drops straight back to IDLE.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; also arms the read timer on entry to a read phase.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (op_e'(req_op))
            OP_LOAD: begin
              state_d  = ST_READ;
              tmr_load = 1'b1;
            end
            OP_STORE: state_d = ST_WRITE;
            OP_CLEAR: state_d = ST_CLEAR;
            default:  state_d = ST_RESP;
          endcase
        end
      end
      ST_READ: begin
        if (tmr_done) state_d = ST_RESP;
      end
      ST_WRITE: begin
`ifdef MEM_CTRL_WRITE_VERIFY_EN
        state_d  = ST_VERIFY;
        tmr_load = 1'b1;
`else
        state_d  = ST_RESP;
`endif
      end
      ST_VERIFY: begin
        if (tmr_done) state_d = ST_RESP;
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory pin drive, decoded from state so reset forces r_w high without waiting for a clock.
  always_comb begin
    r_w          = 1'b1;
    mem_addr_out = '0;
    mem_addr_in  = '0;
    mem_data_in  = '0;
    unique case (state_q)
      ST_READ, ST_VERIFY: mem_addr_out = addr_q;
      ST_WRITE: begin
        r_w         = 1'b0;
        mem_addr_in = addr_q;
        mem_data_in = wdata_q;
      end
      ST_CLEAR: begin
        r_w         = 1'b0;
        mem_addr_in = clr_cnt_q;
      end
      default: ;
    endcase
  end

  // Operand capture on accept, CLEAR sweep counter and response payload.
  // NOTE: these datapath registers are reset so the response outputs are defined straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      clr_cnt_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (accept) begin
      addr_q      <= req_addr;
      wdata_q     <= req_wdata;
      clr_cnt_q   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= (op_e'(req_op) == OP_RSVD);
    end else begin
      if ((state_q == ST_READ) && tmr_done) begin
        rsp_rdata_q <= mem_data_out;
      end
`ifdef MEM_CTRL_WRITE_VERIFY_EN
      if ((state_q == ST_VERIFY) && tmr_done) begin
        rsp_err_q <= (mem_data_out != wdata_q);
      end
`endif
      if ((state_q == ST_CLEAR) && (clr_cnt_q != LAST_ADDR)) begin
        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
      end
      if (rsp_fire) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b0;
      end
    end
  end

endmodule
